// File: rtl/lcd_mode_sequencer_pkg.sv
// Shared video definitions: LCD mode encoding, sequencer states
// and the frame geometry constants.
package lcd_mode_sequencer_pkg;

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        TRANSFER = 2'd3
    } lcd_mode_t;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_OAM,
        ST_XFER,
        ST_HBL,
        ST_VBL
    } seq_state_t;

    localparam int DOTS_PER_LINE   = 456;
    localparam int OAM_SCAN_DOTS   = 80;
    localparam int TRANSFER_DOTS   = 172;
    localparam int LINES_PER_FRAME = 154;
    localparam int LCD_LINES       = 144;

    function automatic lcd_mode_t state_mode(input seq_state_t s);
        unique case (s)
            ST_OAM:  return OAM_SCAN;
            ST_XFER: return TRANSFER;
            ST_VBL:  return VBLANK;
            default: return HBLANK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_mode_sequencer_stat_irq.sv
// STAT interrupt source OR with rising-edge detection, so a line
// held high across consecutive sources yields a single request.
module lcd_stat_irq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic [3:0] stat_int_en,
    input  logic       coincidence,
    input  logic [1:0] mode,
    output logic       stat_irq
);
    import lcd_mode_sequencer_pkg::*;

    logic stat_line;
    logic stat_line_q;

    always_comb begin
        stat_line = active & (
            (stat_int_en[3] & coincidence) |
            (stat_int_en[2] & (mode == OAM_SCAN)) |
            (stat_int_en[1] & (mode == VBLANK)) |
            (stat_int_en[0] & (mode == HBLANK)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_line_q <= 1'b0;
            stat_irq    <= 1'b0;
        end else begin
            stat_line_q <= stat_line;
            stat_irq    <= stat_line & ~stat_line_q;
        end
    end

endmodule

// File: rtl/lcd_mode_sequencer.sv
// Dot-timing sequencer: per-line modes, LY/LYC coincidence,
// VBlank/STAT interrupt requests and CPU VRAM/OAM access grants.
module lcd_mode_sequencer #(
    parameter int DOTS_PER_LINE   = lcd_mode_sequencer_pkg::DOTS_PER_LINE,
    parameter int OAM_SCAN_DOTS   = lcd_mode_sequencer_pkg::OAM_SCAN_DOTS,
    parameter int TRANSFER_DOTS   = lcd_mode_sequencer_pkg::TRANSFER_DOTS,
    parameter int LINES_PER_FRAME = lcd_mode_sequencer_pkg::LINES_PER_FRAME
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [3:0] stat_int_en,
    input  logic [7:0] lyc,
    input  logic       ly_clear,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       line_start,
    output logic       transfer_start,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       cpu_oam_grant,
    output logic       cpu_vram_grant
);
    import lcd_mode_sequencer_pkg::*;

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_XFER = 9'(OAM_SCAN_DOTS);
    localparam logic [8:0] DOT_HBL  = 9'(OAM_SCAN_DOTS + TRANSFER_DOTS);
    localparam logic [7:0] LY_LAST  = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LY_VBL   = 8'(LCD_LINES);

    seq_state_t state, state_n;
    lcd_mode_t  mode_q, mode_n;
    logic [7:0] ly_n;
    logic [8:0] dot_n;
    logic       line_start_n;
    logic       transfer_start_n;
    logic       vblank_n;
    logic       active;

    always_comb begin
        state_n          = state;
        ly_n             = ly;
        dot_n            = dot;
        line_start_n     = 1'b0;
        transfer_start_n = 1'b0;
        vblank_n         = 1'b0;
        if (!lcd_enable) begin
            state_n = ST_OFF;
            ly_n    = 8'd0;
            dot_n   = 9'd0;
        end else if (state == ST_OFF) begin
            state_n      = ST_OAM;
            ly_n         = 8'd0;
            dot_n        = 9'd0;
            line_start_n = 1'b1;
        end else if (dot > DOT_LAST || ly > LY_LAST) begin
            state_n = ST_OFF;
            ly_n    = 8'd0;
            dot_n   = 9'd0;
        end else if (ly_clear) begin
            state_n      = ST_OAM;
            ly_n         = 8'd0;
            dot_n        = 9'd0;
            line_start_n = 1'b1;
        end else if (dot_en) begin
            if (dot == DOT_LAST) begin
                dot_n = 9'd0;
                if (ly == LY_LAST) begin
                    ly_n         = 8'd0;
                    state_n      = ST_OAM;
                    line_start_n = 1'b1;
                end else begin
                    ly_n = ly + 8'd1;
                    if (ly_n >= LY_VBL) begin
                        state_n  = ST_VBL;
                        vblank_n = (ly_n == LY_VBL);
                    end else begin
                        state_n      = ST_OAM;
                        line_start_n = 1'b1;
                    end
                end
            end else begin
                dot_n = dot + 9'd1;
                // VBlank lines stay in mode 1 for the whole line
                if (state != ST_VBL) begin
                    if (dot_n == DOT_XFER) begin
                        state_n          = ST_XFER;
                        transfer_start_n = 1'b1;
                    end else if (dot_n == DOT_HBL) begin
                        state_n = ST_HBL;
                    end
                end
            end
        end
        mode_n = state_mode(state_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_OFF;
            ly             <= 8'd0;
            dot            <= 9'd0;
            mode_q         <= HBLANK;
            coincidence    <= 1'b0;
            line_start     <= 1'b0;
            transfer_start <= 1'b0;
            vblank_irq     <= 1'b0;
            cpu_oam_grant  <= 1'b1;
            cpu_vram_grant <= 1'b1;
        end else begin
            state          <= state_n;
            ly             <= ly_n;
            dot            <= dot_n;
            mode_q         <= mode_n;
            coincidence    <= (state_n != ST_OFF) && (ly_n == lyc);
            line_start     <= line_start_n;
            transfer_start <= transfer_start_n;
            vblank_irq     <= vblank_n;
            cpu_oam_grant  <= (mode_n != OAM_SCAN) && (mode_n != TRANSFER);
            cpu_vram_grant <= (mode_n != TRANSFER);
        end
    end

    assign mode   = mode_q;
    assign active = (state != ST_OFF);

    lcd_stat_irq u_stat_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (active),
        .stat_int_en (stat_int_en),
        .coincidence (coincidence),
        .mode        (mode),
        .stat_irq    (stat_irq)
    );

endmodule
